// File: rtl/seg_scan_mux_if.sv
// Segment scan mux bus: decoded digit patterns in,
// shared segment bus and digit strobes out.
interface seg_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic [7*DIGITS-1:0] seg_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic [3:0]          brightness;
  logic [DIGITS-1:0]   an_out;
  logic [6:0]          seg_out;
  logic                dp_out;
  logic                frame_tick;

  modport master (
    output seg_in,
    output dp_in,
    output digit_en,
    output brightness,
    input  an_out,
    input  seg_out,
    input  dp_out,
    input  frame_tick
  );

  modport slave (
    input  seg_in,
    input  dp_in,
    input  digit_en,
    input  brightness,
    output an_out,
    output seg_out,
    output dp_out,
    output frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver with dead time,
// PWM brightness, per-digit blanking and a frame tick.
module seg_scan_mux #(
  parameter int         DIGITS    = 4,
  parameter int         SCAN_DIV  = 50000,
  parameter int         DEAD      = 500,
  parameter logic [6:0] SEG_BLANK = 7'h7F
) (
  input logic           clk,
  input logic           reset,
  seg_scan_mux_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_C   = PW'(DEAD);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [3:0]        pwm_q, pwm_d;
  logic [6:0]        pat_q, pat_d;
  logic              ldp_q, ldp_d;
  logic              len_q, len_d;
  logic [3:0]        bri_q, bri_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              tick_q, tick_d;

  logic [6:0] cur_pat;
  logic       cur_dp;
  logic       cur_en;
  logic       wrap;
  logic       load;
  logic       lit;

  // Counters, slot-start latch and registered output values.
  always_comb begin
    cur_pat = '0;
    cur_dp  = 1'b1;
    cur_en  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (slot_q == SW'(k)) begin
        cur_pat = bus.seg_in[7*k +: 7];
        cur_dp  = bus.dp_in[k];
        cur_en  = bus.digit_en[k];
      end
    end

    wrap = (pre_cnt_q == PRE_LAST);
    load = (pre_cnt_q == '0);

    pre_cnt_d = wrap ? '0 : pre_cnt_q + 1'b1;
    slot_d    = slot_q;
    if (wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    pwm_d = pwm_q + 4'd1;

    pat_d = load ? cur_pat : pat_q;
    ldp_d = load ? cur_dp : ldp_q;
    len_d = load ? cur_en : len_q;
    bri_d = load ? bus.brightness : bri_q;

    lit = len_q && (pre_cnt_q >= DEAD_C) && (pwm_q <= bri_q);

    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = !(lit && (slot_q == SW'(k)));
    end
    seg_d  = lit ? pat_q : SEG_BLANK;
    dp_d   = lit ? ldp_q : 1'b1;
    tick_d = load && (slot_q == '0);
  end

  // State update; reset aborts any slot in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_q <= '0;
      slot_q    <= '0;
      pwm_q     <= '0;
      pat_q     <= '0;
      ldp_q     <= 1'b1;
      len_q     <= 1'b0;
      bri_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      slot_q    <= slot_d;
      pwm_q     <= pwm_d;
      pat_q     <= pat_d;
      ldp_q     <= ldp_d;
      len_q     <= len_d;
      bri_q     <= bri_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.an_out     = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: scan order, dead time,
// latching, blanking, brightness and reset abort.
module tb_seg_scan_mux;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  logic [27:0] seg_v;
  logic [3:0]  dp_v;
  logic [3:0]  en_v;

  seg_scan_mux_if #(.DIGITS(4)) bus0 ();
  seg_scan_mux_if #(.DIGITS(4)) bus1 ();

  assign bus0.seg_in     = seg_v;
  assign bus0.dp_in      = dp_v;
  assign bus0.digit_en   = en_v;
  assign bus0.brightness = 4'd15;
  assign bus1.seg_in     = seg_v;
  assign bus1.dp_in      = dp_v;
  assign bus1.digit_en   = en_v;
  assign bus1.brightness = 4'd3;

  seg_scan_mux #(
    .DIGITS(4), .SCAN_DIV(8), .DEAD(2), .SEG_BLANK(7'h7F)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  seg_scan_mux #(
    .DIGITS(4), .SCAN_DIV(64), .DEAD(2), .SEG_BLANK(7'h7F)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } vec_t;

  vec_t tbl [14];

  logic [6:0] lat_seg [2][4];
  logic       lat_dp  [2][4];
  logic       lat_en  [2][4];

  logic [3:0] e_an   [2];
  logic [6:0] e_seg  [2];
  logic       e_dp   [2];
  logic       e_tick [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_lat();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin
        lat_seg[d][s] = '0;
        lat_dp[d][s]  = 1'b1;
        lat_en[d][s]  = 1'b0;
      end
    end
  endtask

  // Predict outputs for the edge ending state cycle c-1,
  // update the model latches, advance one clock, compare.
  task automatic run_cycle(input int c);
    for (int d = 0; d < 2; d++) begin
      int sd;
      int br;
      int pre;
      int slt;
      int pw;
      logic lit;
      logic [3:0] one;
      sd  = (d == 0) ? 8 : 64;
      br  = (d == 0) ? 15 : 3;
      pre = (c - 1) % sd;
      slt = ((c - 1) / sd) % 4;
      pw  = (c - 1) % 16;
      lit = lat_en[d][slt] && (pre >= 2) && (pw <= br);
      one = 4'b0001 << slt;
      e_an[d]   = lit ? ~one : 4'hF;
      e_seg[d]  = lit ? lat_seg[d][slt] : 7'h7F;
      e_dp[d]   = lit ? lat_dp[d][slt] : 1'b1;
      e_tick[d] = (pre == 0) && (slt == 0);
      if (pre == 0) begin
        lat_seg[d][slt] = seg_v[slt*7 +: 7];
        lat_dp[d][slt]  = dp_v[slt];
        lat_en[d][slt]  = en_v[slt];
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("an0 c%0d", c), 32'(bus0.an_out), 32'(e_an[0]));
    chk($sformatf("seg0 c%0d", c), 32'(bus0.seg_out), 32'(e_seg[0]));
    chk($sformatf("dp0 c%0d", c), 32'(bus0.dp_out), 32'(e_dp[0]));
    chk($sformatf("tick0 c%0d", c), 32'(bus0.frame_tick),
        32'(e_tick[0]));
    chk($sformatf("an1 c%0d", c), 32'(bus1.an_out), 32'(e_an[1]));
    chk($sformatf("seg1 c%0d", c), 32'(bus1.seg_out), 32'(e_seg[1]));
    chk($sformatf("tick1 c%0d", c), 32'(bus1.frame_tick),
        32'(e_tick[1]));
  endtask

  task automatic chk_blank(input string nm);
    chk({nm, " an0"}, 32'(bus0.an_out), 32'h0000000F);
    chk({nm, " seg0"}, 32'(bus0.seg_out), 32'h0000007F);
    chk({nm, " dp0"}, 32'(bus0.dp_out), 32'h00000001);
    chk({nm, " tick0"}, 32'(bus0.frame_tick), 32'h00000000);
    chk({nm, " an1"}, 32'(bus1.an_out), 32'h0000000F);
  endtask

  int bri_low;
  int bri_mis;
  int an2_low;

  initial begin
    tbl[0]  = '{1,  4'hF, 7'h7F, 1'b1, 1'b1};
    tbl[1]  = '{2,  4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[2]  = '{3,  4'hE, 7'h21, 1'b0, 1'b0};
    tbl[3]  = '{8,  4'hE, 7'h21, 1'b0, 1'b0};
    tbl[4]  = '{9,  4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[5]  = '{10, 4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[6]  = '{11, 4'hD, 7'h46, 1'b1, 1'b0};
    tbl[7]  = '{19, 4'hB, 7'h03, 1'b0, 1'b0};
    tbl[8]  = '{26, 4'hF, 7'h7F, 1'b1, 1'b0};
    tbl[9]  = '{27, 4'h7, 7'h08, 1'b1, 1'b0};
    tbl[10] = '{33, 4'hF, 7'h7F, 1'b1, 1'b1};
    tbl[11] = '{40, 4'hE, 7'h21, 1'b0, 1'b0};
    tbl[12] = '{65, 4'hF, 7'h7F, 1'b1, 1'b1};
    tbl[13] = '{67, 4'hE, 7'h40, 1'b0, 1'b0};

    seg_v = {7'h08, 7'h03, 7'h46, 7'h21};
    dp_v  = 4'b1010;
    en_v  = 4'hF;
    clear_lat();

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_blank($sformatf("reset%0d", i));
    end
    reset = 1'b1;

    bri_low = 0;
    bri_mis = 0;
    an2_low = 0;
    for (int c = 1; c <= 180; c++) begin
      run_cycle(c);
      for (int i = 0; i < 14; i++) begin
        if (tbl[i].c == c) begin
          chk($sformatf("tbl an c%0d", c), 32'(bus0.an_out),
              32'(tbl[i].an));
          chk($sformatf("tbl seg c%0d", c), 32'(bus0.seg_out),
              32'(tbl[i].seg));
          chk($sformatf("tbl dp c%0d", c), 32'(bus0.dp_out),
              32'(tbl[i].dp));
          chk($sformatf("tbl tick c%0d", c), 32'(bus0.frame_tick),
              32'(tbl[i].tick));
        end
      end
      if (c >= 17 && c <= 32 && bus1.an_out[0] == 1'b0) begin
        bri_low++;
        if (((c - 1) % 16) > 3) bri_mis++;
      end
      if (c >= 113 && c <= 160 && bus0.an_out[2] == 1'b0) begin
        an2_low++;
      end
      if (c == 36) seg_v[6:0] = 7'h40;
      if (c == 96) en_v = 4'b1011;
      if (c == 160) en_v = 4'hF;
    end

    chk("bright low count", 32'(bri_low), 32'd4);
    chk("bright misaligned", 32'(bri_mis), 32'd0);
    chk("blank an2 lows", 32'(an2_low), 32'd0);
    chk("slot2 lit before reset", 32'(bus0.an_out), 32'h0000000B);

    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_blank("abort");
    @(posedge clk);
    #1;
    chk_blank("abort2");
    reset = 1'b1;
    clear_lat();

    for (int c = 1; c <= 40; c++) begin
      run_cycle(c);
      if (c == 2) chk("restart c2 an", 32'(bus0.an_out), 32'h0000000F);
      if (c == 3) chk("restart c3 an", 32'(bus0.an_out), 32'h0000000E);
      if (c == 3) chk("restart c3 seg", 32'(bus0.seg_out), 32'h00000040);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
